// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle logical/arithmetic/compare ops, iterative shifts,
// result returned through a valid/ready handshake with one op in flight.
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               alu_op,
    input  logic                     sign,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     overflow
);
    localparam int SW  = $clog2(WIDTH);
    localparam int CW  = SW + 1;
    localparam int MSB = WIDTH - 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00110;
    localparam logic [4:0] OP_SLT = 5'b00111;
    localparam logic [4:0] OP_NOR = 5'b01100;
    localparam logic [4:0] OP_XOR = 5'b01101;
    localparam logic [4:0] OP_SLL = 5'b10000;
    localparam logic [4:0] OP_SRL = 5'b11000;
    localparam logic [4:0] OP_SRA = 5'b11001;

    // Two's-complement overflow: operands agree in sign, sum disagrees.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic [CW-1:0]    r_rem;
    logic [1:0]       r_kind;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_lt;
    logic [WIDTH-1:0] w_calc_res;
    logic             w_calc_ovf;
    logic             w_is_shift;
    logic [1:0]       w_kind;
    logic [CW-1:0]    w_step;
    logic [CW-1:0]    w_rem_next;
    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign w_accept  = in_valid && in_ready;

    // Single-cycle datapath; unlisted codes fall through to add.
    always_comb begin
        w_sum      = in_a + in_b;
        w_diff     = in_a - in_b;
        w_add_ovf  = add_ovf(in_a[MSB], in_b[MSB], w_sum[MSB]);
        w_sub_ovf  = add_ovf(in_a[MSB], ~in_b[MSB], w_diff[MSB]);
        w_lt       = sign ? (w_diff[MSB] ^ w_sub_ovf) : (in_a < in_b);
        w_calc_res = w_sum;
        w_calc_ovf = sign & w_add_ovf;
        w_is_shift = 1'b0;
        w_kind     = K_SLL;
        case (alu_op)
            OP_AND: begin w_calc_res = in_a & in_b;    w_calc_ovf = 1'b0; end
            OP_OR:  begin w_calc_res = in_a | in_b;    w_calc_ovf = 1'b0; end
            OP_SUB: begin w_calc_res = w_diff;         w_calc_ovf = sign & w_sub_ovf; end
            OP_SLT: begin w_calc_res = {{(WIDTH-1){1'b0}}, w_lt}; w_calc_ovf = 1'b0; end
            OP_NOR: begin w_calc_res = ~(in_a | in_b); w_calc_ovf = 1'b0; end
            OP_XOR: begin w_calc_res = in_a ^ in_b;    w_calc_ovf = 1'b0; end
            OP_SLL: begin w_calc_res = in_b; w_calc_ovf = 1'b0; w_is_shift = 1'b1; w_kind = K_SLL; end
            OP_SRL: begin w_calc_res = in_b; w_calc_ovf = 1'b0; w_is_shift = 1'b1; w_kind = K_SRL; end
            OP_SRA: begin w_calc_res = in_b; w_calc_ovf = 1'b0; w_is_shift = 1'b1; w_kind = K_SRA; end
            default: begin w_calc_res = w_sum; w_calc_ovf = sign & w_add_ovf; end
        endcase
    end

    // One shift iteration of at most SHIFT_STEP positions.
    always_comb begin
        if (r_rem < STEP_C) begin
            w_step = r_rem;
        end else begin
            w_step = STEP_C;
        end
        w_rem_next = r_rem - w_step;
        case (r_kind)
            K_SLL:   w_shifted = r_result << w_step;
            K_SRL:   w_shifted = r_result >> w_step;
            K_SRA:   w_shifted = WIDTH'($signed(r_result) >>> w_step);
            default: w_shifted = r_result;
        endcase
    end

    // Control FSM and result registers; reset outranks flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_rem    <= {CW{1'b0}};
            r_kind   <= K_SLL;
        end else if (flush) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_is_shift && (in_shamt != {SW{1'b0}})) begin
                        r_result <= in_b;
                        r_rem    <= CW'(in_shamt);
                        r_kind   <= w_kind;
                        r_zero   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= ST_SHIFT;
                    end else if (w_accept) begin
                        r_result <= w_calc_res;
                        r_zero   <= (w_calc_res == {WIDTH{1'b0}});
                        r_ovf    <= w_calc_ovf;
                        r_state  <= ST_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_result <= w_shifted;
                    r_rem    <= w_rem_next;
                    if (w_rem_next == {CW{1'b0}}) begin
                        r_zero  <= (w_shifted == {WIDTH{1'b0}});
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against a behavioural
// reference model that tracks per-op latency and expected outputs.
module tb_alu_exec_unit;
    localparam int W    = 32;
    localparam int STEP = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_op = 5'd0;
    logic        sign = 1'b0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [4:0]  in_shamt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .sign(sign), .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .overflow(overflow)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic is_shift(input logic [4:0] op);
        return (op == 5'b10000) || (op == 5'b11000) || (op == 5'b11001);
    endfunction

    function automatic longint ext(input logic [31:0] v, input logic sg);
        return sg ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [31:0] f_res(input logic [4:0] op, input logic sg,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh);
        logic signed [31:0] sb;
        sb = b;
        case (op)
            5'b00000: return a & b;
            5'b00001: return a | b;
            5'b00110: return a - b;
            5'b00111: return (ext(a, sg) < ext(b, sg)) ? 32'd1 : 32'd0;
            5'b01100: return ~(a | b);
            5'b01101: return a ^ b;
            5'b10000: return b << sh;
            5'b11000: return b >> sh;
            5'b11001: return sb >>> sh;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic f_ovf(input logic [4:0] op, input logic sg,
                                   input logic [31:0] a, input logic [31:0] b);
        longint s;
        if (!sg) return 1'b0;
        case (op)
            5'b00000, 5'b00001, 5'b00111, 5'b01100, 5'b01101,
            5'b10000, 5'b11000, 5'b11001: return 1'b0;
            5'b00110: s = ext(a, 1'b1) - ext(b, 1'b1);
            default:  s = ext(a, 1'b1) + ext(b, 1'b1);
        endcase
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic int f_lat(input logic [4:0] op, input logic [4:0] sh);
        if (is_shift(op) && sh != 5'd0) return (int'(sh) + STEP - 1) / STEP;
        return 0;
    endfunction

    // Reference model: cycles left until result, pending result, handshake state.
    int          m_wait  = 0;
    logic        m_valid = 1'b0;
    logic        m_init  = 1'b0;
    logic        m_clr   = 1'b0;
    logic [31:0] m_res   = 32'd0;
    logic        m_zero  = 1'b0;
    logic        m_ovf   = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            m_init <= 1'b1; m_clr <= 1'b1; m_valid <= 1'b0; m_wait <= 0;
            m_res <= 32'd0; m_zero <= 1'b0; m_ovf <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0; m_wait <= 0;
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_valid <= 1'b1;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (in_valid) begin
            m_clr  <= 1'b0;
            m_res  <= f_res(alu_op, sign, in_a, in_b, in_shamt);
            m_zero <= (f_res(alu_op, sign, in_a, in_b, in_shamt) == 32'd0);
            m_ovf  <= f_ovf(alu_op, sign, in_a, in_b);
            m_wait <= f_lat(alu_op, in_shamt);
            m_valid <= (f_lat(alu_op, in_shamt) == 0);
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (m_init) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (m_wait == 0) && !m_valid});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid || m_clr) begin
                check("result", result, m_res);
                check("zero", {31'd0, zero}, {31'd0, m_zero});
                check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
            end
        end
    end

    task automatic run_op(input logic [4:0] op, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input int hold,
                          output logic [31:0] got, output logic got_z, output logic got_o,
                          output int lat);
        int t;
        @(negedge clk);
        alu_op = op; sign = sg; in_a = a; in_b = b; in_shamt = sh;
        in_valid = 1'b1; out_ready = 1'b0;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        alu_op = 5'($urandom); sign = 1'($urandom); in_a = $urandom; in_b = $urandom;
        in_shamt = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        check("latency", lat, 1 + f_lat(op, sh));
        repeat (hold) @(negedge clk);
        got = result; got_z = zero; got_o = overflow;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] g;
        logic        gz, go;
        int          lat;
        logic [4:0]  ops [12];
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
                5'b01101, 5'b10000, 5'b11000, 5'b11001, 5'b11111, 5'b01010};

        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", result, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);

        check("model_add", f_res(5'b00010, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0), 32'h80000000);
        check("model_sra", f_res(5'b11001, 1'b1, 32'd0, 32'h80000000, 5'd31), 32'hFFFFFFFF);
        check("model_slt", f_res(5'b00111, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0), 32'd1);

        run_op(5'b00010, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0, 0, g, gz, go, lat);
        check("add_s_res", g, 32'h80000000); check("add_s_ovf", {31'd0, go}, 32'd1);
        check("add_s_zero", {31'd0, gz}, 32'd0); check("add_lat", lat, 32'd1);
        run_op(5'b00010, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd0, 0, g, gz, go, lat);
        check("add_u_ovf", {31'd0, go}, 32'd0);
        run_op(5'b00111, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0, 1, g, gz, go, lat);
        check("slt_s", g, 32'd1);
        run_op(5'b00111, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0, 0, g, gz, go, lat);
        check("slt_u", g, 32'd0);
        run_op(5'b00110, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0, 0, g, gz, go, lat);
        check("sub", g, 32'hFFFFFFFE);
        run_op(5'b11001, 1'b0, 32'd0, 32'h80000000, 5'd31, 0, g, gz, go, lat);
        check("sra_res", g, 32'hFFFFFFFF); check("sra_lat", lat, 32'd32);
        run_op(5'b11000, 1'b0, 32'd0, 32'h80000000, 5'd31, 0, g, gz, go, lat);
        check("srl_res", g, 32'd1);
        run_op(5'b10000, 1'b0, 32'd0, 32'h12345678, 5'd0, 0, g, gz, go, lat);
        check("sll0_res", g, 32'h12345678); check("sll0_lat", lat, 32'd1);
        run_op(5'b01101, 1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 5'd0, 5, g, gz, go, lat);
        check("xor_res", g, 32'd0); check("xor_zero", {31'd0, gz}, 32'd1);

        // Flush on the third cycle of a 20-position shift.
        @(negedge clk);
        alu_op = 5'b10000; in_b = 32'd1; in_shamt = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        repeat (25) begin
            @(negedge clk);
            check("flush_no_valid", {31'd0, out_valid}, 32'd0);
        end
        alu_op = 5'b00000; in_a = 32'hF; in_b = 32'hF; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_req", {31'd0, out_valid}, 32'd0);

        run_op(5'b11111, 1'b0, 32'd3, 32'd4, 5'd0, 0, g, gz, go, lat);
        check("undef_add", g, 32'd7);

        // Reset while shifting discards the op.
        @(negedge clk);
        alu_op = 5'b11001; in_b = 32'h80000000; in_shamt = 5'd31; sign = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_zero", {31'd0, zero}, 32'd0);
        check("rst_mid_ovf", {31'd0, overflow}, 32'd0);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(negedge clk);
        check("rst_mid_novalid", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'h7FFFFFFF;
            if ($urandom_range(0, 4) == 0) rb = 32'h80000000;
            if ($urandom_range(0, 6) == 0) rb = ra;
            run_op(ops[$urandom_range(0, 11)], 1'($urandom), ra, rb, 5'($urandom),
                   $urandom_range(0, 3), g, gz, go, lat);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
